// File: rtl/ads1675_serial_rx.sv
// ADS1675 serial receiver: oversamples SCLK/DRDY/DOUT in the aclk domain and emits sign-extended samples on AXI4-Stream.
// Optional stall timeout in SHIFT is enabled by defining ADS_RX_TIMEOUT_EN.
module ads1675_serial_rx #(
    parameter int DATA_WIDTH     = 24,
    parameter int OUT_WIDTH      = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 en,
    input  logic                 sclk,
    input  logic                 drdy,
    input  logic                 dout,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 busy,
    output logic                 frame_err,
    output logic [15:0]          overrun_cnt
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("ads1675_serial_rx: SYNC_STAGES must be at least 2");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("ads1675_serial_rx: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Synchronizers: bit 2 = sclk, bit 1 = drdy, bit 0 = dout
    // ------------------------------------------------------------------
    logic [2:0] sync_q [SYNC_STAGES];
    logic [1:0] hist_q;

    // NOTE: synchronizer flops are reset so no false edge is seen right after reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= {sclk, drdy, dout};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hist_q <= sync_q[SYNC_STAGES-1][2:1];
        end
    end

    logic sclk_s, drdy_s, dout_s;
    logic sclk_rise, drdy_fall;

    assign sclk_s    = sync_q[SYNC_STAGES-1][2];
    assign drdy_s    = sync_q[SYNC_STAGES-1][1];
    assign dout_s    = sync_q[SYNC_STAGES-1][0];
    assign sclk_rise = sclk_s & ~hist_q[1];
    assign drdy_fall = ~drdy_s & hist_q[0];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-2:0] shreg_q, shreg_d;
    logic                  ferr_q, ferr_d;
    logic                  frame_done;
`ifdef ADS_RX_TIMEOUT_EN
    localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]      tmo_q, tmo_d;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        ferr_d     = 1'b0;
        frame_done = 1'b0;
`ifdef ADS_RX_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (drdy_fall) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        shreg_d = '0;
`ifdef ADS_RX_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
                SHIFT: begin
                    // A DRDY fall beats a coincident SCLK rise: the frame restarts.
                    if (drdy_fall) begin
                        ferr_d  = 1'b1;
                        cnt_d   = '0;
                        shreg_d = '0;
`ifdef ADS_RX_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end else if (sclk_rise) begin
                        if (cnt_q == LAST_CNT) begin
                            frame_done = 1'b1;
                            state_d    = IDLE;
                            cnt_d      = '0;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            shreg_d = {shreg_q[DATA_WIDTH-3:0], dout_s};
                        end
`ifdef ADS_RX_TIMEOUT_EN
                        tmo_d = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        ferr_d  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                        shreg_d = '0;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            ferr_q  <= 1'b0;
`ifdef ADS_RX_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ferr_q  <= ferr_d;
`ifdef ADS_RX_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Single-entry output register
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] sample;
    logic [OUT_WIDTH-1:0]  sample_ext;
    logic [OUT_WIDTH-1:0]  tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic [15:0]           ovr_q, ovr_d;
    logic                  drain;

    assign sample     = {shreg_q, dout_s};
    assign sample_ext = {{(OUT_WIDTH - DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};
    assign drain      = tvalid_q & m_axis_tready;

    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        ovr_d    = ovr_q;
        if (drain) tvalid_d = 1'b0;
        if (frame_done) begin
            if (!tvalid_q || drain) begin
                tvalid_d = 1'b1;
                tdata_d  = sample_ext;
            end else if (ovr_q != 16'hFFFF) begin
                ovr_d = ovr_q + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            ovr_q    <= '0;
        end else begin
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            ovr_q    <= ovr_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q == SHIFT);
    assign frame_err     = ferr_q;
    assign overrun_cnt   = ovr_q;

endmodule

// File: doc/ads1675_serial_rx.md
# ads1675_serial_rx

PL-side receiver for the ADS1675 serial sample interface (SCLK/DRDY/DOUT after the LVDS input buffers). Oversamples the three lines in the `aclk` domain, detects frame start on DRDY falling, shifts in 24 MSB-first bits on SCLK rising edges, and presents each sign-extended sample on an AXI4-Stream master port feeding the axi4l_fifo write side. It is the receive end of the ADS1675 source model used in the collection-system bench.

## Interface
- `DATA_WIDTH`, 24: bits per ADC frame.
- `OUT_WIDTH`, 32: stream width; sample sign-extended from bit `DATA_WIDTH-1`.
- `SYNC_STAGES`, 2: synchronizer flops on `sclk`/`drdy`/`dout` (min 2).
- `TIMEOUT_CYCLES`, 256: stall limit used only with `ADS_RX_TIMEOUT_EN`.

- `aclk` in 1: sole clock; all logic on rising edge.
- `aresetn` in 1: reset, asynchronous assert, active-low.
- `en` in 1: capture enable.
- `sclk` in 1: ADC serial clock, asynchronous to `aclk`; frequency ≤ `aclk`/4.
- `drdy` in 1: ADC data-ready, active-low, asynchronous.
- `dout` in 1: ADC serial data, asynchronous, valid at `sclk` rising.
- `m_axis_tdata` out `OUT_WIDTH`: sample.
- `m_axis_tvalid` out 1: sample valid.
- `m_axis_tready` in 1: downstream ready.
- `busy` out 1: high in SHIFT state.
- `frame_err` out 1: one-cycle pulse on aborted frame.
- `overrun_cnt` out 16: saturating count of dropped samples.

## Operation
- `sclk`, `drdy`, `dout` each pass through `SYNC_STAGES` flops plus one history flop; edges detected as sync/history pairs. `dout` uses identical depth so it is aligned with the detected `sclk` rise.
- States: IDLE, SHIFT.
  - IDLE: `en`=1 and DRDY falling → SHIFT, bit count cleared, shift register cleared.
  - SHIFT: each SCLK rising shifts `dout` into LSB, count+1. On the rise making count = `DATA_WIDTH` → load output register, → IDLE.
  - SHIFT, DRDY falling before count reaches `DATA_WIDTH` → `frame_err` pulse, partial discarded, restart SHIFT with count 0 (new frame).
  - `en`=0 in any state → IDLE next cycle, partial discarded, no `frame_err`.
- Output register: single entry. Load when complete frame arrives and register empty or draining (`tvalid`&&`tready` same cycle). If full and not draining, new sample dropped, `overrun_cnt` +1 saturating at 16'hFFFF; held sample unchanged.
- `tdata` stable while `tvalid`=1 and `tready`=0; `tvalid` deasserts only on handshake.
- `overrun_cnt` cleared only by reset.

## Timing
- Reset: state IDLE, `m_axis_tvalid`=0, `m_axis_tdata`=0, `busy`=0, `frame_err`=0, `overrun_cnt`=0, synchronizers 0.
- Edge detect latency: `SYNC_STAGES`+1 `aclk` cycles after input pin change.
- Last SCLK rise detected in cycle N → `m_axis_tvalid`=1 in cycle N+1.
- DRDY fall detected in cycle N → `busy`=1 in cycle N+1.
- DRDY fall and SCLK rise detected in same cycle: DRDY wins (frame restart, bit not shifted).
- Frame completion and handshake in same cycle: old sample leaves, new loaded, `tvalid` stays 1, no overrun.
- `frame_err` asserted cycle after detection, one cycle wide.

## Configuration
- `ADS_RX_TIMEOUT_EN` defined: SHIFT state counts `aclk` cycles since last SCLK rise (or DRDY fall); reaching `TIMEOUT_CYCLES` → `frame_err` pulse, → IDLE, partial discarded. Counter reset on every SCLK rise.
- Undefined: no timeout counter; SHIFT waits indefinitely for SCLK or DRDY; `TIMEOUT_CYCLES` ignored.

## Test plan
- Frame 24'h800001, `tready`=1 → `tdata`=32'hFF800001, one `tvalid` cycle; frame 24'h12_3456 → 32'h0012_3456.
- 1000 random frames, SCLK = `aclk`/4, `tready` random 50% with sample period > drain time → every frame received in order, `overrun_cnt`=0.
- `tready`=0, three complete frames → first sample held, `overrun_cnt`=2; `tready`=1 → first sample delivered once.
- DRDY falls after 10 bits, then full frame 24'hABCDEF → one `frame_err` pulse, only 32'hFFABCDEF delivered.
- `en` dropped after 12 bits, raised, next full frame 24'h000007 → no `frame_err`, only 32'h00000007 delivered.
- With `ADS_RX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=256: SCLK stops after 5 bits → `frame_err` 256 cycles after last rise, `busy`=0; without macro `busy` stays 1.
